mem_stage_lsu: RTL and testbench

Load/store unit for the MEM stage of the pipelined RV32 core. It consumes the registered address, store data and memory controls from the EX/MEM pipeline register, performs one bus transaction per load or store over a req/ack data bus, and returns extended load data toward MEM/WB. While a transaction is in flight it holds `o_stall` high so the hazard unit freezes the front of the pipeline. Misaligned and unsupported accesses are flagged without touching the bus.

---
 rtl/lsu_pkg.sv | 57 +++++
 rtl/lsu_load_align.sv | 37 +++
 rtl/mem_stage_lsu.sv | 165 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and access-decode helpers for the MEM-stage load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned FUNC_W = 3;
  localparam int unsigned CNT_W  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [FUNC_W-1:0] F_B  = 3'b000;
  localparam logic [FUNC_W-1:0] F_H  = 3'b001;
  localparam logic [FUNC_W-1:0] F_W  = 3'b010;
  localparam logic [FUNC_W-1:0] F_BU = 3'b100;
  localparam logic [FUNC_W-1:0] F_HU = 3'b101;

  // Halves need bit 0 clear, words need both low bits clear; bytes are always aligned.
  function automatic logic lsu_is_misaligned(input logic [FUNC_W-1:0] func,
                                             input logic [1:0]        lo);
    case (func[1:0])
      2'b01:   return lo[0];
      2'b10:   return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic lsu_is_supported(input logic              is_store,
                                            input logic [FUNC_W-1:0] func);
    if (is_store) return (func == F_B) || (func == F_H) || (func == F_W);
    return (func == F_B) || (func == F_H) || (func == F_W) ||
           (func == F_BU) || (func == F_HU);
  endfunction

  function automatic logic [BE_W-1:0] lsu_byte_en(input logic [FUNC_W-1:0] func,
                                                  input logic [1:0]        lo);
    case (func[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Sub-word store data is replicated so whichever lane is enabled carries it.
  function automatic logic [XLEN-1:0] lsu_store_data(input logic [FUNC_W-1:0] func,
                                                     input logic [XLEN-1:0]   wdata);
    case (func[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane select and sign/zero extension by funct3 and address low bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [FUNC_W-1:0] i_func,
  input  logic [1:0]        i_addr_lo,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [XLEN-1:0]   o_data
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = i_rdata[7:0];
    half_c = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_addr_lo)
      2'd0:    byte_c = i_rdata[7:0];
      2'd1:    byte_c = i_rdata[15:8];
      2'd2:    byte_c = i_rdata[23:16];
      default: byte_c = i_rdata[31:24];
    endcase
  end

  always_comb begin
    o_data = '0;
    case (i_func)
      F_B:     o_data = {{24{byte_c[7]}}, byte_c};
      F_H:     o_data = {{16{half_c[15]}}, half_c};
      F_W:     o_data = i_rdata;
      F_BU:    o_data = {24'd0, byte_c};
      F_HU:    o_data = {16'd0, half_c};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one req/ack bus transaction per legal access, stalling the
// front of the pipeline while it is in flight and flagging illegal accesses without bus traffic.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic              i_mem_wren,
  input  logic              i_lsu_sel,
  input  logic [FUNC_W-1:0] i_func,
  output logic              o_stall,
  output logic [XLEN-1:0]   o_ld_data,
  output logic              o_ld_valid,
  output logic              o_misalign,
  output logic              o_bus_err,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [XLEN-1:0]   o_bus_addr,
  output logic [BE_W-1:0]   o_bus_be,
  output logic [XLEN-1:0]   o_bus_wdata,
  input  logic [XLEN-1:0]   i_bus_rdata,
  input  logic              i_bus_ack
);

  lsu_state_e state_q, state_d;

  logic [XLEN-1:0]   addr_q,    addr_d;
  logic [1:0]        lo_q,      lo_d;
  logic [BE_W-1:0]   be_q,      be_d;
  logic [XLEN-1:0]   wdata_q,   wdata_d;
  logic              we_q,      we_d;
  logic [FUNC_W-1:0] func_q,    func_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [XLEN-1:0]   ld_data_q, ld_data_d;
  logic              err_q,     err_d;

  logic            pending_c;
  logic            illegal_c;
  logic            accept_c;
  logic            timeout_c;
  logic [XLEN-1:0] align_c;

  assign pending_c = i_mem_wren | i_lsu_sel;
  assign illegal_c = !lsu_is_supported(i_mem_wren, i_func) ||
                     lsu_is_misaligned(i_func, i_addr[1:0]);
  assign accept_c  = (state_q == IDLE) && pending_c && !illegal_c;
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT));

  lsu_load_align u_load_align (
    .i_func    (func_q),
    .i_addr_lo (lo_q),
    .i_rdata   (i_bus_rdata),
    .o_data    (align_c)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = BUSY;
      BUSY:    if (i_bus_ack || timeout_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus fields latch only on acceptance; ack takes precedence over an expiring counter.
  always_comb begin
    addr_d    = addr_q;
    lo_d      = lo_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    func_d    = func_q;
    cnt_d     = cnt_q;
    ld_data_d = ld_data_q;
    err_d     = err_q;
    if (accept_c) begin
      addr_d  = {i_addr[XLEN-1:2], 2'b00};
      lo_d    = i_addr[1:0];
      be_d    = lsu_byte_en(i_func, i_addr[1:0]);
      wdata_d = i_mem_wren ? lsu_store_data(i_func, i_wdata) : '0;
      we_d    = i_mem_wren;
      func_d  = i_func;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (i_bus_ack) begin
        ld_data_d = align_c;
        err_d     = 1'b0;
      end else if (timeout_c) begin
        ld_data_d = '0;
        err_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q    <= '0;
      lo_q      <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      func_q    <= '0;
      cnt_q     <= '0;
      ld_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      lo_q      <= lo_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      func_q    <= func_d;
      cnt_q     <= cnt_d;
      ld_data_q <= ld_data_d;
      err_q     <= err_d;
    end
  end

  // Stall and illegal-access strobes react to the EX/MEM inputs in the same IDLE cycle.
  always_comb begin
    o_stall    = 1'b0;
    o_bus_req  = 1'b0;
    o_ld_valid = 1'b0;
    o_ld_data  = '0;
    o_misalign = 1'b0;
    o_bus_err  = 1'b0;
    if (!i_rst) begin
      case (state_q)
        IDLE: begin
          o_stall    = accept_c;
          o_misalign = pending_c && illegal_c;
          o_ld_valid = pending_c && illegal_c && !i_mem_wren;
        end
        BUSY: begin
          o_stall   = 1'b1;
          o_bus_req = 1'b1;
        end
        DONE: begin
          o_ld_valid = !we_q;
          o_ld_data  = we_q ? '0 : ld_data_q;
          o_bus_err  = err_q;
        end
        default: ;
      endcase
    end
  end

  assign o_bus_we    = we_q;
  assign o_bus_addr  = addr_q;
  assign o_bus_be    = be_q;
  assign o_bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: loads, stores, illegal accesses, timeout and reset-in-flight.
module tb_mem_stage_lsu;
  import lsu_pkg::*;

  localparam int unsigned TO = 4;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_mem_wren;
  logic        i_lsu_sel;
  logic [2:0]  i_func;
  logic        o_stall;
  logic [31:0] o_ld_data;
  logic        o_ld_valid;
  logic        o_misalign;
  logic        o_bus_err;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic [31:0] i_bus_rdata;
  logic        i_bus_ack;

  int n_checks;
  int n_pass;

  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_mem_wren  (i_mem_wren),
    .i_lsu_sel   (i_lsu_sel),
    .i_func      (i_func),
    .o_stall     (o_stall),
    .o_ld_data   (o_ld_data),
    .o_ld_valid  (o_ld_valid),
    .o_misalign  (o_misalign),
    .o_bus_err   (o_bus_err),
    .o_bus_req   (o_bus_req),
    .o_bus_we    (o_bus_we),
    .o_bus_addr  (o_bus_addr),
    .o_bus_be    (o_bus_be),
    .o_bus_wdata (o_bus_wdata),
    .i_bus_rdata (i_bus_rdata),
    .i_bus_ack   (i_bus_ack)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    i_addr      = '0;
    i_wdata     = '0;
    i_mem_wren  = 1'b0;
    i_lsu_sel   = 1'b0;
    i_func      = '0;
    i_bus_ack   = 1'b0;
  endtask

  // Starts in IDLE just after a rising edge; ends the same way. ack_at < 0 means no ack.
  task automatic run_access(input string tag, input logic we, input logic [2:0] fn,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int ack_at,
                            input logic [31:0] e_baddr, input logic [3:0] e_be,
                            input logic [31:0] e_bwd, input logic [31:0] e_ld,
                            input logic e_err, input int e_reqs);
    int  reqs;
    int  stalls;
    bit  done;
    i_addr      = addr;
    i_wdata     = wd;
    i_mem_wren  = we;
    i_lsu_sel   = !we;
    i_func      = fn;
    i_bus_rdata = rd;
    reqs   = 0;
    stalls = 0;
    done   = 1'b0;
    @(negedge i_clk);
    chk({tag, "/idle_req"}, 32'(o_bus_req), 32'd0);
    if (o_stall) stalls++;
    for (int n = 0; n < 64 && !done; n++) begin
      @(posedge i_clk);
      #1;
      i_bus_ack = (n == ack_at);
      @(negedge i_clk);
      if (o_bus_req) begin
        reqs++;
        if (o_stall) stalls++;
        chk({tag, "/bus_addr"}, o_bus_addr, e_baddr);
        chk({tag, "/bus_be"}, 32'(o_bus_be), 32'(e_be));
        chk({tag, "/bus_we"}, 32'(o_bus_we), 32'(we));
        if (we) chk({tag, "/bus_wdata"}, o_bus_wdata, e_bwd);
      end else begin
        done = 1'b1;
        chk({tag, "/done_stall"}, 32'(o_stall), 32'd0);
        chk({tag, "/ld_valid"}, 32'(o_ld_valid), 32'(!we));
        if (!we) chk({tag, "/ld_data"}, o_ld_data, e_ld);
        chk({tag, "/bus_err"}, 32'(o_bus_err), 32'(e_err));
        chk({tag, "/misalign"}, 32'(o_misalign), 32'd0);
      end
    end
    chk({tag, "/reached_done"}, 32'(done), 32'd1);
    chk({tag, "/req_cycles"}, 32'(reqs), 32'(e_reqs));
    chk({tag, "/stall_cycles"}, 32'(stalls), 32'(e_reqs + 1));
    clear_inputs();
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_illegal(input string tag, input logic we, input logic [2:0] fn,
                             input logic [31:0] addr);
    i_addr     = addr;
    i_wdata    = 32'h1234_5678;
    i_mem_wren = we;
    i_lsu_sel  = !we;
    i_func     = fn;
    @(negedge i_clk);
    chk({tag, "/misalign"}, 32'(o_misalign), 32'd1);
    chk({tag, "/ld_valid"}, 32'(o_ld_valid), 32'(!we));
    if (!we) chk({tag, "/ld_data"}, o_ld_data, 32'd0);
    chk({tag, "/stall"}, 32'(o_stall), 32'd0);
    chk({tag, "/req"}, 32'(o_bus_req), 32'd0);
    @(posedge i_clk);
    #1;
    clear_inputs();
    @(negedge i_clk);
    chk({tag, "/stays_idle"}, 32'(o_bus_req), 32'd0);
    chk({tag, "/strobe_gone"}, 32'(o_misalign), 32'd0);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    i_rst       = 1'b1;
    i_bus_rdata = '0;
    clear_inputs();
    #1;
    chk("rst/stall", 32'(o_stall), 32'd0);
    chk("rst/req", 32'(o_bus_req), 32'd0);
    chk("rst/ld_valid", 32'(o_ld_valid), 32'd0);
    chk("rst/bus_addr", o_bus_addr, 32'd0);
    chk("rst/bus_be", 32'(o_bus_be), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    run_access("lw_100", 1'b0, F_W, 32'h100, 32'h0, 32'hDEADBEEF, 0,
               32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, 1);
    run_access("lb_103", 1'b0, F_B, 32'h103, 32'h0, 32'h80FFFFFF, 0,
               32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, 1);
    run_access("lbu_103", 1'b0, F_BU, 32'h103, 32'h0, 32'h80FFFFFF, 1,
               32'h100, 4'b1000, 32'h0, 32'h00000080, 1'b0, 2);
    run_access("lhu_102", 1'b0, F_HU, 32'h102, 32'h0, 32'h80FFFFFF, 2,
               32'h100, 4'b1100, 32'h0, 32'h000080FF, 1'b0, 3);
    run_access("lh_102", 1'b0, F_H, 32'h102, 32'h0, 32'h80FF1234, 0,
               32'h100, 4'b1100, 32'h0, 32'hFFFF80FF, 1'b0, 1);
    run_access("lb_101", 1'b0, F_B, 32'h101, 32'h0, 32'h00007F00, 0,
               32'h100, 4'b0010, 32'h0, 32'h0000007F, 1'b0, 1);
    run_access("sb_201", 1'b1, F_B, 32'h201, 32'h000000A5, 32'h0, 0,
               32'h200, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0, 1);
    run_access("sh_202", 1'b1, F_H, 32'h202, 32'hFFFF1234, 32'h0, 1,
               32'h200, 4'b1100, 32'h12341234, 32'h0, 1'b0, 2);
    run_access("sw_300", 1'b1, F_W, 32'h300, 32'hCAFEF00D, 32'h0, 0,
               32'h300, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, 1);

    run_illegal("lw_mis", 1'b0, F_W, 32'h102);
    run_illegal("lf3_unsup", 1'b0, 3'b011, 32'h100);
    run_illegal("sh_mis", 1'b1, F_H, 32'h201);
    run_illegal("sbu_unsup", 1'b1, F_BU, 32'h200);

    run_access("lw_timeout", 1'b0, F_W, 32'h400, 32'h0, 32'h11112222, -1,
               32'h400, 4'b1111, 32'h0, 32'h0, 1'b1, 5);
    run_access("lw_ack_last", 1'b0, F_W, 32'h404, 32'h0, 32'h33334444, 4,
               32'h404, 4'b1111, 32'h0, 32'h33334444, 1'b0, 5);

    // Reset while the bus is still waiting for its ack.
    i_addr      = 32'h500;
    i_mem_wren  = 1'b0;
    i_lsu_sel   = 1'b1;
    i_func      = F_W;
    i_bus_rdata = 32'hFFFF0000;
    @(posedge i_clk);
    #1;
    @(posedge i_clk);
    #1;
    chk("rst_busy/req_before", 32'(o_bus_req), 32'd1);
    i_rst = 1'b1;
    #1;
    chk("rst_busy/req", 32'(o_bus_req), 32'd0);
    chk("rst_busy/stall", 32'(o_stall), 32'd0);
    chk("rst_busy/ld_valid", 32'(o_ld_valid), 32'd0);
    chk("rst_busy/bus_err", 32'(o_bus_err), 32'd0);
    chk("rst_busy/misalign", 32'(o_misalign), 32'd0);
    clear_inputs();
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    run_access("lw_after_rst", 1'b0, F_W, 32'h104, 32'h0, 32'h13579BDF, 0,
               32'h104, 4'b1111, 32'h0, 32'h13579BDF, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
